// File: rtl/pwm_multicanal.sv
// Multi-channel PWM generator: shared prescaled period counter (edge/center aligned),
// one-entry shadow buffer loaded by valid/ready, duty swapped in at period boundaries.
module pwm_multicanal #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      modo,
  input  logic [CHANNELS*WIDTH-1:0] amostra,
  input  logic                      amostra_valida,
  output logic                      amostra_pronta,
  output logic [CHANNELS-1:0]       saida,
  output logic                      fim_periodo,
  output logic                      underrun
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CONT_MAX  = '1;
  localparam logic [WIDTH-1:0] CONT_LAST = CONT_MAX - 1'b1;

  typedef enum logic {MODO_BORDA, MODO_CENTRO} modo_t;
  typedef enum logic {SOBE, DESCE} dir_t;

  logic [PW-1:0]             pre, pre_nxt;
  logic [WIDTH-1:0]          cont, cont_nxt;
  dir_t                      dir, dir_nxt;
  modo_t                     modo_at, modo_nxt;
  logic                      tick, fronteira;
  logic [WIDTH-1:0]          duty [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] sombra;
  logic                      cheio, armado, transfere;

  assign amostra_pronta = ~cheio & ~rst;
  assign transfere      = amostra_valida & amostra_pronta;

  always_comb begin
    pre_nxt   = pre;
    cont_nxt  = cont;
    dir_nxt   = dir;
    modo_nxt  = modo_at;
    tick      = enable && (pre == PRE_LAST);
    fronteira = 1'b0;
    if (enable)
      pre_nxt = tick ? '0 : pre + 1'b1;
    if (tick) begin
      if (modo_at == MODO_BORDA)
        fronteira = (cont == CONT_LAST);
      else
        fronteira = (dir == DESCE) && (cont == '0);
    end
    // Both modes restart at 0 counting up after a boundary, so a mode switch needs no extra path.
    if (fronteira) begin
      cont_nxt = '0;
      dir_nxt  = SOBE;
      modo_nxt = modo_t'(modo);
    end else if (tick) begin
      if (modo_at == MODO_BORDA)
        cont_nxt = cont + 1'b1;
      else if (dir == SOBE) begin
        if (cont == CONT_LAST)
          dir_nxt = DESCE;
        else
          cont_nxt = cont + 1'b1;
      end else
        cont_nxt = cont - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre         <= '0;
      cont        <= '0;
      dir         <= SOBE;
      modo_at     <= MODO_BORDA;
      sombra      <= '0;
      cheio       <= 1'b0;
      armado      <= 1'b0;
      saida       <= '0;
      fim_periodo <= 1'b0;
      underrun    <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++)
        duty[i] <= '0;
    end else begin
      pre         <= pre_nxt;
      cont        <= cont_nxt;
      dir         <= dir_nxt;
      modo_at     <= modo_nxt;
      fim_periodo <= fronteira;
      for (int unsigned i = 0; i < CHANNELS; i++)
        saida[i] <= enable && (cont < duty[i]);
      if (fronteira) begin
        if (cheio) begin
          for (int unsigned i = 0; i < CHANNELS; i++)
            duty[i] <= sombra[i*WIDTH +: WIDTH];
          cheio <= 1'b0;
        end else if (armado)
          underrun <= 1'b1;
      end
      // Transfer only happens with the shadow empty, so it never collides with the load above.
      if (transfere) begin
        sombra <= amostra;
        cheio  <= 1'b1;
        armado <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Directed bench for pwm_multicanal: WIDTH=4, two channels, PRESCALE 1 and 3 instances.
module tb_pwm_multicanal;

  logic       clk = 1'b0;
  logic       rst, enable, modo, valida;
  logic [7:0] amostra;
  logic       pronta, fim, under;
  logic [1:0] saida;

  logic       rst_b, en_b, modo_b, valida_b;
  logic [7:0] amostra_b;
  logic       pronta_b, fim_b, under_b;
  logic [1:0] saida_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_multicanal #(.WIDTH(4), .CHANNELS(2), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .modo(modo), .amostra(amostra),
    .amostra_valida(valida), .amostra_pronta(pronta), .saida(saida),
    .fim_periodo(fim), .underrun(under)
  );

  pwm_multicanal #(.WIDTH(4), .CHANNELS(2), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .modo(modo_b), .amostra(amostra_b),
    .amostra_valida(valida_b), .amostra_pronta(pronta_b), .saida(saida_b),
    .fim_periodo(fim_b), .underrun(under_b)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst = 1'b1; enable = 1'b0; valida = 1'b0; modo = m; amostra = '0;
    step();
    step();
    rst = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; valida = 1'b1; modo = 1'b0; amostra = 8'hFF;
    step();
    step();
    n_cmp++; if (saida !== 2'b00) begin n_err++; $display("FAIL reset_saida got %b want 00", saida); end
    n_cmp++; if (fim !== 1'b0) begin n_err++; $display("FAIL reset_fim got %b want 0", fim); end
    n_cmp++; if (under !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b want 0", under); end
    n_cmp++; if (pronta !== 1'b0) begin n_err++; $display("FAIL reset_pronta_in_rst got %b want 0", pronta); end
    valida = 1'b0; rst = 1'b0;
    #1;
    n_cmp++; if (pronta !== 1'b1) begin n_err++; $display("FAIL reset_pronta_after got %b want 1", pronta); end
  endtask

  task automatic test_no_load;
    logic fe;
    do_reset(1'b0);
    for (int k = 1; k <= 31; k++) begin
      step();
      fe = (k % 15 == 0);
      n_cmp++; if (saida !== 2'b00) begin n_err++; $display("FAIL noload_saida k=%0d got %b want 00", k, saida); end
      n_cmp++; if (fim !== fe) begin n_err++; $display("FAIL noload_fim k=%0d got %b want %b", k, fim, fe); end
      n_cmp++; if (under !== 1'b0) begin n_err++; $display("FAIL noload_underrun k=%0d got %b want 0", k, under); end
    end
  endtask

  task automatic test_edge;
    logic [1:0] se;
    logic fe, pe, ue;
    do_reset(1'b0);
    amostra = 8'hF5; valida = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 1) valida = 1'b0;
      se[0] = (k >= 16) && (((k - 16) % 15) < 5);
      se[1] = (k >= 16);
      fe = (k % 15 == 0);
      pe = (k >= 15);
      ue = (k >= 30);
      n_cmp++; if (saida !== se) begin n_err++; $display("FAIL edge_saida k=%0d got %b want %b", k, saida, se); end
      n_cmp++; if (fim !== fe) begin n_err++; $display("FAIL edge_fim k=%0d got %b want %b", k, fim, fe); end
      n_cmp++; if (pronta !== pe) begin n_err++; $display("FAIL edge_pronta k=%0d got %b want %b", k, pronta, pe); end
      n_cmp++; if (under !== ue) begin n_err++; $display("FAIL edge_underrun k=%0d got %b want %b", k, under, ue); end
    end
  endtask

  task automatic test_center;
    logic [1:0] se;
    logic fe, ue;
    int j;
    do_reset(1'b1);
    amostra = 8'h03; valida = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      step();
      if (k == 1) valida = 1'b0;
      j = (k - 16) % 30;
      se = {1'b0, (k >= 16) && ((j < 3) || (j >= 27))};
      fe = (k == 15) || (k == 45) || (k == 75);
      ue = (k >= 45);
      n_cmp++; if (saida !== se) begin n_err++; $display("FAIL center_saida k=%0d got %b want %b", k, saida, se); end
      n_cmp++; if (fim !== fe) begin n_err++; $display("FAIL center_fim k=%0d got %b want %b", k, fim, fe); end
      n_cmp++; if (under !== ue) begin n_err++; $display("FAIL center_underrun k=%0d got %b want %b", k, under, ue); end
    end
  endtask

  task automatic test_prescale;
    logic [1:0] se;
    logic fe, ue;
    rst_b = 1'b1; en_b = 1'b0; valida_b = 1'b0; modo_b = 1'b0; amostra_b = '0;
    step();
    step();
    rst_b = 1'b0; en_b = 1'b1; amostra_b = 8'h01; valida_b = 1'b1;
    for (int k = 1; k <= 95; k++) begin
      step();
      if (k == 1) valida_b = 1'b0;
      se = {1'b0, (k >= 46) && (((k - 46) % 45) < 3)};
      fe = (k % 45 == 0);
      ue = (k >= 90);
      n_cmp++; if (saida_b !== se) begin n_err++; $display("FAIL presc_saida k=%0d got %b want %b", k, saida_b, se); end
      n_cmp++; if (fim_b !== fe) begin n_err++; $display("FAIL presc_fim k=%0d got %b want %b", k, fim_b, fe); end
      n_cmp++; if (under_b !== ue) begin n_err++; $display("FAIL presc_underrun k=%0d got %b want %b", k, under_b, ue); end
    end
    rst_b = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [1:0] se;
    logic fe, pe, ue;
    int d;
    do_reset(1'b0);
    amostra = 8'h07; valida = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 1) amostra = 8'h0C;
      if (k == 14) valida = 1'b0;
      if (k == 29) begin amostra = 8'h0A; valida = 1'b1; end
      if (k == 30) valida = 1'b0;
      d = (k >= 46) ? 10 : 7;
      se = {1'b0, (k >= 16) && (((k - 16) % 15) < d)};
      fe = (k % 15 == 0);
      pe = !((k < 15) || ((k >= 30) && (k < 45)));
      ue = (k >= 30);
      n_cmp++; if (saida !== se) begin n_err++; $display("FAIL b2b_saida k=%0d got %b want %b", k, saida, se); end
      n_cmp++; if (fim !== fe) begin n_err++; $display("FAIL b2b_fim k=%0d got %b want %b", k, fim, fe); end
      n_cmp++; if (pronta !== pe) begin n_err++; $display("FAIL b2b_pronta k=%0d got %b want %b", k, pronta, pe); end
      n_cmp++; if (under !== ue) begin n_err++; $display("FAIL b2b_underrun k=%0d got %b want %b", k, under, ue); end
    end
  endtask

  task automatic test_reset_mid;
    logic fe;
    do_reset(1'b0);
    amostra = 8'h05; valida = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) valida = 1'b0;
      if (k == 16) begin amostra = 8'h09; valida = 1'b1; end
      if (k == 17) valida = 1'b0;
    end
    n_cmp++; if (saida !== 2'b01) begin n_err++; $display("FAIL rstmid_pre_saida got %b want 01", saida); end
    n_cmp++; if (pronta !== 1'b0) begin n_err++; $display("FAIL rstmid_pre_pronta got %b want 0", pronta); end
    rst = 1'b1;
    step();
    n_cmp++; if (saida !== 2'b00) begin n_err++; $display("FAIL rstmid_saida got %b want 00", saida); end
    n_cmp++; if (fim !== 1'b0) begin n_err++; $display("FAIL rstmid_fim got %b want 0", fim); end
    n_cmp++; if (under !== 1'b0) begin n_err++; $display("FAIL rstmid_underrun got %b want 0", under); end
    n_cmp++; if (pronta !== 1'b0) begin n_err++; $display("FAIL rstmid_pronta_in_rst got %b want 0", pronta); end
    rst = 1'b0;
    #1;
    n_cmp++; if (pronta !== 1'b1) begin n_err++; $display("FAIL rstmid_pronta_after got %b want 1", pronta); end
    for (int k = 1; k <= 30; k++) begin
      step();
      fe = (k % 15 == 0);
      n_cmp++; if (saida !== 2'b00) begin n_err++; $display("FAIL rstmid_discard_saida k=%0d got %b want 00", k, saida); end
      n_cmp++; if (fim !== fe) begin n_err++; $display("FAIL rstmid_discard_fim k=%0d got %b want %b", k, fim, fe); end
      n_cmp++; if (under !== 1'b0) begin n_err++; $display("FAIL rstmid_discard_underrun k=%0d got %b want 0", k, under); end
    end
  endtask

  task automatic test_disable;
    logic [1:0] se;
    logic fe, pe, ue;
    int c, d;
    do_reset(1'b0);
    amostra = 8'h05; valida = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      step();
      if (k == 1) valida = 1'b0;
      if (k == 17) enable = 1'b0;
      if (k == 19) begin amostra = 8'h0B; valida = 1'b1; end
      if (k == 20) valida = 1'b0;
      if (k == 24) enable = 1'b1;
      if (k <= 15) begin
        se = 2'b00; fe = (k == 15);
      end else if (k <= 17) begin
        se = 2'b01; fe = 1'b0;
      end else if (k <= 24) begin
        se = 2'b00; fe = 1'b0;
      end else begin
        c = (k - 23) % 15;
        d = (k >= 38) ? 11 : 5;
        se = {1'b0, c < d};
        fe = (c == 14);
      end
      pe = !((k < 15) || ((k >= 20) && (k < 37)));
      ue = (k >= 52);
      n_cmp++; if (saida !== se) begin n_err++; $display("FAIL dis_saida k=%0d got %b want %b", k, saida, se); end
      n_cmp++; if (fim !== fe) begin n_err++; $display("FAIL dis_fim k=%0d got %b want %b", k, fim, fe); end
      n_cmp++; if (pronta !== pe) begin n_err++; $display("FAIL dis_pronta k=%0d got %b want %b", k, pronta, pe); end
      n_cmp++; if (under !== ue) begin n_err++; $display("FAIL dis_underrun k=%0d got %b want %b", k, under, ue); end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; modo = 1'b0; valida = 1'b0; amostra = '0;
    rst_b = 1'b1; en_b = 1'b0; modo_b = 1'b0; valida_b = 1'b0; amostra_b = '0;
    test_reset();
    test_no_load();
    test_edge();
    test_center();
    test_prescale();
    test_back_to_back();
    test_reset_mid();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
